// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard/stall/flush sequencer for a 5-stage MIPS pipeline.
// Keeps shadow EX/MEM/WB copies of destination/control and a saturating stall counter.
// Optional feature macro: FORWARD_EN (defined = stall only on load-use against EX;
// undefined = stall on any RAW match against EX or MEM).
module hazard_ctrl #(
    parameter int          CNT_W    = 16,
    parameter logic [4:0]  REG_ZERO = 5'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Shadow pipeline state
    logic             ex_valid_q,  ex_valid_d;
    logic [4:0]       ex_dest_q,   ex_dest_d;
    logic             ex_rw_q,     ex_rw_d;
    logic             ex_mr_q,     ex_mr_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_dest_q,  mem_dest_d;
    logic             mem_rw_q,    mem_rw_d;
    logic             mem_mr_q,    mem_mr_d;
    logic             wb_valid_q,  wb_valid_d;
    logic [4:0]       wb_dest_q,   wb_dest_d;
    logic             wb_rw_q,     wb_rw_d;
    logic             wb_mr_q,     wb_mr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic uses_rs_s;
    logic uses_rt_s;
    logic hit_ex_s;
    logic hit_mem_s;
    logic hazard_s;
    logic stall_s;
    logic is_jump_s;

    // RAW match of the ID sources against one older destination
    function automatic logic src_match(
        input logic       valid,
        input logic       reg_write,
        input logic [4:0] dest,
        input logic       use_rs,
        input logic       use_rt,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return valid & reg_write & (dest != REG_ZERO) &
               ((use_rs & (rs == dest)) | (use_rt & (rt == dest)));
    endfunction

    // Decode which source fields the ID instruction actually reads
    always_comb begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b0;
        is_jump_s = 1'b0;
        case (id_opcode)
            OP_RTYPE: uses_rt_s = 1'b1;
            OP_BEQ:   uses_rt_s = 1'b1;
            OP_BNE:   uses_rt_s = 1'b1;
            OP_SW:    uses_rt_s = 1'b1;
            OP_J: begin
                uses_rs_s = 1'b0;
                is_jump_s = 1'b1;
            end
            OP_JAL: begin
                uses_rs_s = 1'b0;
                is_jump_s = 1'b1;
            end
            OP_LUI:   uses_rs_s = 1'b0;
            default: begin
                uses_rs_s = 1'b1;
                uses_rt_s = 1'b0;
            end
        endcase
    end

    // Hazard detection; reset suppresses any stall so a pending one is abandoned
    always_comb begin
        hit_ex_s  = src_match(ex_valid_q, ex_rw_q, ex_dest_q,
                              uses_rs_s, uses_rt_s, id_rs, id_rt);
        hit_mem_s = src_match(mem_valid_q, mem_rw_q, mem_dest_q,
                              uses_rs_s, uses_rt_s, id_rs, id_rt);
`ifdef FORWARD_EN
        hazard_s  = hit_ex_s & ex_mr_q;
`else
        hazard_s  = hit_ex_s | hit_mem_s;
`endif
        stall_s   = id_valid & hazard_s & ~rst;
    end

    // Pipeline control outputs, zero-cycle latency from ID inputs
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else begin
            pc_write    = ~stall_s;
            ifid_write  = ~stall_s;
            idex_bubble = stall_s;
            ifid_flush  = id_valid & ~stall_s & is_jump_s;
        end
    end

    // Next shadow state: a stalled or empty ID slot enters EX as a bubble
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_dest_d   = 5'd0;
        ex_rw_d     = 1'b0;
        ex_mr_d     = 1'b0;
        if (id_valid & ~stall_s) begin
            ex_valid_d = 1'b1;
            ex_dest_d  = id_dest;
            ex_rw_d    = id_reg_write;
            ex_mr_d    = id_mem_read;
        end else begin
            ex_valid_d = 1'b0;
        end
        mem_valid_d = ex_valid_q;
        mem_dest_d  = ex_dest_q;
        mem_rw_d    = ex_rw_q;
        mem_mr_d    = ex_mr_q;
        wb_valid_d  = mem_valid_q;
        wb_dest_d   = mem_dest_q;
        wb_rw_d     = mem_rw_q;
        wb_mr_d     = mem_mr_q;
    end

    // Saturating stall counter next value
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= 5'd0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= 5'd0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= 5'd0;
            wb_rw_q     <= 1'b0;
            wb_mr_q     <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_rw_q    <= mem_rw_d;
            mem_mr_q    <= mem_mr_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            wb_rw_q     <= wb_rw_d;
            wb_mr_q     <= wb_mr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // WB never creates a hazard (write-first register file) and the mode not
    // selected leaves some shadow bits without a reader; gather them here.
    logic unused_shadow_s;
    assign unused_shadow_s = ^{wb_valid_q, wb_dest_q, wb_rw_q, wb_mr_q,
                               mem_mr_q, ex_mr_q, hit_mem_s};

endmodule
